qmult_pipe: RTL and testbench
=============================

Name: qmult_pipe

Overview:
- Pipelined, multi-lane signed fixed-point (Q-format) multiplier. Successor to the combinational Q multiplier used in the GRU/LSTM datapath.
- Adds a valid/ready handshake, per-beat selectable rounding and saturation, per-lane overflow flags and sticky overflow status.
- Sits between the weight/activation fetch logic and the gate accumulators; one beat multiplies LANES independent operand pairs.

Parameters:
- N, 16, total bits per operand and result, sign bit included (N >= 4).
- Q, 12, fractional bits (1 <= Q <= N-2).
- LANES, 4, independent multiplier lanes per beat.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- a  in  LANES*N  multiplicands; lane i = a[i*N +: N], two's complement.
- b  in  LANES*N  multipliers, same packing as a.
- round_en  in  1  1 = round half up on magnitude; 0 = truncate. Sampled with the beat.
- sat_en  in  1  1 = saturate on overflow; 0 = wrap. Sampled with the beat.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- q_result  out  LANES*N  products in Q-format, same packing as a.
- overflow  out  LANES  per-lane overflow flag for the current output beat.
- ovf_sticky  out  LANES  per-lane overflow history.
- ovf_clr  in  1  synchronous clear of ovf_sticky.

Behaviour:
- Reset (rst=0, async): all pipeline valids=0, out_valid=0, q_result=0, overflow=0, ovf_sticky=0.
- Two register stages, fixed latency 2 cycles from an accepted input to out_valid when there is no stall.
- Global advance: adv = ~out_valid | out_ready. in_ready = adv, combinational.
- An input transfer occurs on in_valid & in_ready.
- When adv=0, every stage holds. out_valid, q_result and overflow stay stable until the transfer. No beat is dropped or duplicated.
- Bubbles: an invalid stage advances as a bubble. A stage-1 bubble is not a stall, so throughput is 1 beat/cycle.
- Stage 1 (registered): per lane:
  - mag_a = a<0 ? -a : a, as an N-bit unsigned value; 0x8000 gives magnitude 2^(N-1).
  - Same for mag_b.
  - P = mag_a*mag_b, 2N bits unsigned.
  - neg = a[N-1]^b[N-1].
  - round_en and sat_en are registered alongside P.
- Stage 2 (registered): per lane:
  - R = (P + (round_en ? 2^(Q-1) : 0)) >> Q, 2N-Q+1 bits.
  - negr = neg & (R != 0). A zero product is never negative.
  - ovf = negr ? (R > 2^(N-1)) : (R > 2^(N-1)-1).
  - sat_en=1 and ovf: result = negr ? 2^(N-1) (min) : 2^(N-1)-1 (max).
  - Otherwise: result = negr ? -(R[N-1:0]) : R[N-1:0], N-bit wrap.
  - overflow[i] = ovf, regardless of sat_en.
- Sticky status:
  - ovf_sticky[i] sets when an output transfer (out_valid & out_ready) carries overflow[i]=1.
  - ovf_clr clears ovf_sticky. A simultaneous set and clear leaves the bit at 1.
  - ovf_clr has no effect on the data path.
- Mode bits are per beat: a change of round_en or sat_en between beats never affects a beat already accepted.
- Lanes are fully independent. All lanes share one handshake.
- Reset asserted mid-operation discards all in-flight beats. The first beat after reset release follows the normal 2-cycle latency.

Test Plan (N=16, Q=12, LANES=4, out_ready=1 unless stated):
- Basic: lane0 a=0x1800 (1.5), b=0x2000 (2.0); lane1 a=0xE800 (-1.5), b=0x2000; lanes2-3 zero -> two cycles after the transfer: q_result lane0=0x3000, lane1=0xD000, lanes2-3=0x0000, overflow=0.
- Overflow: a=0x3000, b=0x3000 (3*3=9). sat_en=1 -> 0x7FFF, overflow=1. sat_en=0 -> 0x9000, overflow=1. Then a=0xE000, b=0x4000 (-2*4) -> 0x8000, overflow=0.
- Rounding: a=0x0001, b=0x0800. round_en=0 -> 0x0000; round_en=1 -> 0x0001. a=0xFFFF, b=0x0800: round_en=0 -> 0x0000 (no negative zero); round_en=1 -> 0xFFFF.
- Backpressure: continuous in_valid with incrementing operands; out_ready=0 for 3 cycles -> in_ready=0 once both stages are full, outputs held stable, every beat appears once and in order after release.
- Sticky: overflow beat on lane2 -> ovf_sticky=0b0100 and it persists over later clean beats. ovf_clr pulsed in the same cycle as a new lane2 overflow transfer -> stays 0b0100. ovf_clr alone -> 0b0000.
- Reset: assert rst low with 2 beats in flight -> out_valid=0, q_result=0, ovf_sticky=0 immediately. After release, a new beat gives its result 2 cycles later with no stale output.

Source files
------------

// File: rtl/qmult_pipe.sv
// rtl/qmult_pipe.sv - two-stage pipelined multi-lane signed Q-format multiplier
//
// Purpose:
//   Multiplies LANES independent pairs of N-bit two's complement Q-format
//   operands (Q fractional bits) per beat. Rounding and saturation are chosen
//   per beat. Fixed latency is two cycles, one beat per cycle is accepted, and
//   a single global advance signal stalls both stages together.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   in_valid   in   input beat valid
//   in_ready   out  input beat can be accepted (combinational from out side)
//   a, b       in   LANES*N operands, lane i = [i*N +: N]
//   round_en   in   1 = round half up on magnitude, 0 = truncate
//   sat_en     in   1 = saturate on overflow, 0 = wrap
//   out_valid  out  result beat valid
//   out_ready  in   downstream accepts result beat
//   q_result   out  LANES*N products, same packing as a
//   overflow   out  per-lane overflow of the current output beat
//   ovf_sticky out  per-lane overflow history of transferred beats
//   ovf_clr    in   synchronous clear of ovf_sticky
module qmult_pipe #(
    parameter int N     = 16,
    parameter int Q     = 12,
    parameter int LANES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES*N-1:0]   a,
    input  logic [LANES*N-1:0]   b,
    input  logic                 round_en,
    input  logic                 sat_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*N-1:0]   q_result,
    output logic [LANES-1:0]     overflow,
    output logic [LANES-1:0]     ovf_sticky,
    input  logic                 ovf_clr
);

    localparam int PW = 2 * N;          // magnitude product width
    localparam int RW = 2 * N - Q + 1;  // rescaled magnitude width (room for round carry)

    // Half an LSB of the result, added to the magnitude before the shift.
    localparam logic [PW:0]   RND_INC = {{PW{1'b0}}, 1'b1} << (Q - 1);
    // Largest representable magnitudes: 2^(N-1)-1 positive, 2^(N-1) negative.
    localparam logic [RW-1:0] POS_LIM = {{(RW - N + 1){1'b0}}, {(N - 1){1'b1}}};
    localparam logic [RW-1:0] NEG_LIM = {{(RW - N){1'b0}}, 1'b1, {(N - 1){1'b0}}};
    localparam logic [N-1:0]  MAX_VAL = {1'b0, {(N - 1){1'b1}}};
    localparam logic [N-1:0]  MIN_VAL = {1'b1, {(N - 1){1'b0}}};

    logic                     adv;

    // Stage 1 registers: magnitude products plus sign and the beat's modes.
    logic                     s1_valid_q, s1_valid_d;
    logic [LANES-1:0][PW-1:0] s1_p_q, s1_p_d;
    logic [LANES-1:0]         s1_neg_q, s1_neg_d;
    logic                     s1_round_q, s1_round_d;
    logic                     s1_sat_q, s1_sat_d;

    // Stage 2 registers: the visible output beat.
    logic                     out_valid_q, out_valid_d;
    logic [LANES-1:0][N-1:0]  res_q, res_d;
    logic [LANES-1:0]         ovf_q, ovf_d;
    logic [LANES-1:0]         sticky_q, sticky_d;

    // Combinational per-lane results feeding each stage.
    logic [LANES-1:0][PW-1:0] prod_c;
    logic [LANES-1:0]         neg_c;
    logic [LANES-1:0][N-1:0]  res_c;
    logic [LANES-1:0]         ovf_c;

    // Both stages move together; the only stall source is a held output.
    assign adv      = ~out_valid_q | out_ready;
    assign in_ready = adv;

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            logic [N-1:0]  a_l, b_l, mag_a, mag_b;
            logic [PW:0]   sum;
            logic [RW-1:0] r;
            logic [N-1:0]  low;
            logic          negr;
            logic          ovf;

            // Stage 1: sign/magnitude split. The most negative operand maps to
            // magnitude 2^(N-1), which still fits as an N-bit unsigned value.
            assign a_l         = a[g*N +: N];
            assign b_l         = b[g*N +: N];
            assign mag_a       = a_l[N-1] ? -a_l : a_l;
            assign mag_b       = b_l[N-1] ? -b_l : b_l;
            assign prod_c[g]   = {{N{1'b0}}, mag_a} * {{N{1'b0}}, mag_b};
            assign neg_c[g]    = a_l[N-1] ^ b_l[N-1];

            // Stage 2: round on magnitude, rescale, then reapply the sign.
            assign sum  = {1'b0, s1_p_q[g]} + (s1_round_q ? RND_INC : '0);
            assign r    = RW'(sum >> Q);
            // A product that rounds or truncates to zero must not become negative.
            assign negr = s1_neg_q[g] & (r != '0);
            assign ovf  = negr ? (r > NEG_LIM) : (r > POS_LIM);
            assign low  = r[N-1:0];

            assign res_c[g] = (s1_sat_q && ovf) ? (negr ? MIN_VAL : MAX_VAL)
                                                : (negr ? -low : low);
            assign ovf_c[g] = ovf;
        end
    endgenerate

    // Next-state: valids follow the global advance; data registers only load
    // when a real beat enters them, so bubbles leave the last data in place.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_p_d      = s1_p_q;
        s1_neg_d    = s1_neg_q;
        s1_round_d  = s1_round_q;
        s1_sat_d    = s1_sat_q;
        out_valid_d = out_valid_q;
        res_d       = res_q;
        ovf_d       = ovf_q;

        if (adv) begin
            s1_valid_d  = in_valid;
            out_valid_d = s1_valid_q;
            if (in_valid) begin
                s1_p_d     = prod_c;
                s1_neg_d   = neg_c;
                s1_round_d = round_en;
                s1_sat_d   = sat_en;
            end
            if (s1_valid_q) begin
                res_d = res_c;
                ovf_d = ovf_c;
            end
        end

        // Set wins over clear so an overflow transferring in the clear cycle is kept.
        sticky_d = (sticky_q & ~{LANES{ovf_clr}})
                 | ({LANES{out_valid_q & out_ready}} & ovf_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q  <= 1'b0;
            s1_p_q      <= '0;
            s1_neg_q    <= '0;
            s1_round_q  <= 1'b0;
            s1_sat_q    <= 1'b0;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            ovf_q       <= '0;
            sticky_q    <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_p_q      <= s1_p_d;
            s1_neg_q    <= s1_neg_d;
            s1_round_q  <= s1_round_d;
            s1_sat_q    <= s1_sat_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            ovf_q       <= ovf_d;
            sticky_q    <= sticky_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign q_result   = res_q;
    assign overflow   = ovf_q;
    assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_qmult_pipe.sv
// tb/tb_qmult_pipe.sv - directed self-checking bench for qmult_pipe
module tb_qmult_pipe;

    localparam int N     = 16;
    localparam int Q     = 12;
    localparam int LANES = 4;
    localparam int NB    = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [LANES*N-1:0]   a;
    logic [LANES*N-1:0]   b;
    logic                 round_en;
    logic                 sat_en;
    logic                 out_valid;
    logic                 out_ready;
    logic [LANES*N-1:0]   q_result;
    logic [LANES-1:0]     overflow;
    logic [LANES-1:0]     ovf_sticky;
    logic                 ovf_clr;

    int total = 0;
    int bad   = 0;

    logic [63:0] expq[$];
    logic [63:0] held;
    logic        held_ok;
    int          k;
    int          got;

    always #5 clk = ~clk;

    qmult_pipe #(.N(N), .Q(Q), .LANES(LANES)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .round_en   (round_en),
        .sat_en     (sat_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .q_result   (q_result),
        .overflow   (overflow),
        .ovf_sticky (ovf_sticky),
        .ovf_clr    (ovf_clr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one beat, then returns #1 after the edge where its result appears.
    task automatic beat(input logic [63:0] av, input logic [63:0] bv,
                        input logic rnd, input logic sat);
        a        = av;
        b        = bv;
        round_en = rnd;
        sat_en   = sat;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("latency_not_1", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk("latency_2_valid", 64'(out_valid), 64'd1);
    endtask

    // Backpressure stream: lanes 1..3 times 1.0 return the operand, lane0 is
    // 1 LSB times 0.5, which yields 1 only when the beat's round_en is set.
    function automatic logic [63:0] mk_a(input int kv);
        logic [15:0] kk;
        kk = 16'(kv);
        return {16'hFFFF - kk, 16'h0200 + kk, 16'h0100 + (kk << 2), 16'h0001};
    endfunction

    function automatic logic [63:0] mk_exp(input int kv);
        logic [15:0] kk;
        kk = 16'(kv);
        return {16'hFFFF - kk, 16'h0200 + kk, 16'h0100 + (kk << 2), 15'h0000, kk[0]};
    endfunction

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        round_en  = 1'b0;
        sat_en    = 1'b0;
        out_ready = 1'b1;
        ovf_clr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_q_result", q_result, 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_sticky", 64'(ovf_sticky), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;

        // Basic: 1.5*2.0 and -1.5*2.0
        beat(64'h0000_0000_E800_1800, 64'h0000_0000_2000_2000, 1'b0, 1'b0);
        chk("basic_q", q_result, 64'h0000_0000_D000_3000);
        chk("basic_ovf", 64'(overflow), 64'd0);

        // Overflow 3*3=9, saturate then wrap; -2*4 fits exactly at min
        beat(64'h0000_0000_0000_3000, 64'h0000_0000_0000_3000, 1'b0, 1'b1);
        chk("ovf_sat_q", q_result, 64'h0000_0000_0000_7FFF);
        chk("ovf_sat_flag", 64'(overflow), 64'h1);
        beat(64'h0000_0000_0000_3000, 64'h0000_0000_0000_3000, 1'b0, 1'b0);
        chk("ovf_wrap_q", q_result, 64'h0000_0000_0000_9000);
        chk("ovf_wrap_flag", 64'(overflow), 64'h1);
        beat(64'h0000_0000_0000_E000, 64'h0000_0000_0000_4000, 1'b0, 1'b1);
        chk("min_exact_q", q_result, 64'h0000_0000_0000_8000);
        chk("min_exact_flag", 64'(overflow), 64'h0);

        // Most-negative operand corners: lane0 -8*-8, lane1 -8*1, lane2 ~8*1, lane3 -8*-1
        beat(64'h8000_7FFF_8000_8000, 64'hF000_1000_1000_8000, 1'b0, 1'b1);
        chk("corner_sat_q", q_result, 64'h7FFF_7FFF_8000_7FFF);
        chk("corner_sat_flag", 64'(overflow), 64'h9);
        beat(64'h8000_7FFF_8000_8000, 64'hF000_1000_1000_8000, 1'b0, 1'b0);
        chk("corner_wrap_q", q_result, 64'h8000_7FFF_8000_0000);
        chk("corner_wrap_flag", 64'(overflow), 64'h9);

        // Rounding: lane0 +1LSB*0.5, lane1 -1LSB*0.5
        beat(64'h0000_0000_FFFF_0001, 64'h0000_0000_0800_0800, 1'b0, 1'b0);
        chk("rnd_trunc_q", q_result, 64'h0000_0000_0000_0000);
        beat(64'h0000_0000_FFFF_0001, 64'h0000_0000_0800_0800, 1'b1, 1'b0);
        chk("rnd_round_q", q_result, 64'h0000_0000_FFFF_0001);
        chk("rnd_round_flag", 64'(overflow), 64'h0);
        @(posedge clk); #1;

        // Backpressure with per-beat round_en and a 3-cycle output stall
        k       = 0;
        got     = 0;
        held    = '0;
        held_ok = 1'b0;
        for (int c = 0; c < 60 && got < NB; c++) begin
            out_ready = !(c >= 4 && c <= 6);
            if (k < NB) begin
                a        = mk_a(k);
                b        = 64'h1000_1000_1000_0800;
                round_en = k[0];
                sat_en   = 1'b0;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && !out_ready) begin
                chk("bp_stall_in_ready", 64'(in_ready), 64'd0);
                if (held_ok) chk("bp_hold_q", q_result, held);
                held    = q_result;
                held_ok = 1'b1;
            end else begin
                held_ok = 1'b0;
            end
            if (out_valid && out_ready) begin
                chk("bp_order_q", q_result, expq.size() > 0 ? expq.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD);
                got++;
            end
            if (in_valid && in_ready) begin
                expq.push_back(mk_exp(k));
                k++;
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_count", 64'(got), 64'(NB));
        chk("bp_leftover", 64'(expq.size()), 64'd0);

        // Sticky status
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        chk("stk_pre_clear", 64'(ovf_sticky), 64'h0);
        beat(64'h0000_3000_0000_0000, 64'h0000_3000_0000_0000, 1'b0, 1'b1);
        chk("stk_lane2_flag", 64'(overflow), 64'h4);
        @(posedge clk); #1;
        chk("stk_set", 64'(ovf_sticky), 64'h4);
        beat(64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b0, 1'b1);
        chk("stk_clean_flag", 64'(overflow), 64'h0);
        @(posedge clk); #1;
        chk("stk_persist", 64'(ovf_sticky), 64'h4);
        beat(64'h0000_3000_0000_0000, 64'h0000_3000_0000_0000, 1'b0, 1'b1);
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        chk("stk_set_beats_clr", 64'(ovf_sticky), 64'h4);
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        chk("stk_clr_alone", 64'(ovf_sticky), 64'h0);

        // Reset with two beats in flight
        beat(64'h0000_0000_3000_0000, 64'h0000_0000_3000_0000, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("rst2_pre_sticky", 64'(ovf_sticky), 64'h2);
        a        = 64'h0000_0000_0000_3000;
        b        = 64'h0000_0000_0000_3000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        a        = 64'h0000_0000_0000_1800;
        b        = 64'h0000_0000_0000_2000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rst2_pre_valid", 64'(out_valid), 64'd1);
        rst = 1'b0;
        #1;
        chk("rst2_out_valid", 64'(out_valid), 64'd0);
        chk("rst2_q_result", q_result, 64'd0);
        chk("rst2_overflow", 64'(overflow), 64'd0);
        chk("rst2_sticky", 64'(ovf_sticky), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst2_no_stale", 64'(out_valid), 64'd0);
        end
        beat(64'h0000_0000_E800_1800, 64'h0000_0000_2000_2000, 1'b0, 1'b0);
        chk("rst2_after_q", q_result, 64'h0000_0000_D000_3000);
        chk("rst2_after_ovf", 64'(overflow), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
